adc_frontend: RTL and testbench

ADC_FRONTEND -- requirements
Module: adc_frontend

---
 rtl/adc_frontend_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 39 +++
 rtl/adc_frontend.sv | 174 +++++++++++++++++
 tb/tb_adc_frontend.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frontend_pkg.sv
// Shared types and frame constants for the ADC front end (pre-amp writer + ADC frame reader).
package adc_frontend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AMP_LOAD,
        CONV,
        ADC_READ,
        GAP
    } state_t;

    localparam int FRAME_BITS = 34;  // SPI_CLK periods per ADC read frame
    localparam int AMP_BITS   = 8;   // pre-amp gain word length
    localparam int CH0_FIRST  = 3;   // 1-based frame bit holding the ch0 MSB
    localparam int CH1_FIRST  = 19;  // 1-based frame bit holding the ch1 MSB
    localparam int SAMPLE_W   = 14;  // converter resolution

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock divider: one tick every CLK_DIV clk cycles, alternating rise/fall strobes.
// The strobes are high in the clk cycle before the SPI_CLK edge they announce, so logic
// acting on a strobe updates on the same clk edge that moves SPI_CLK.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sck_rise,
    output logic sck_fall,
    output logic SPI_CLK
);

    logic [7:0] div_cnt_reg;
    logic       phase_reg;
    logic       tick;

    // counter never reaches CLK_DIV-1 while held at zero, so no strobe fires when idle
    assign tick = (div_cnt_reg == 8'(CLK_DIV - 1));

    // restart from zero whenever run drops so every transaction begins with a full low half-period
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt_reg <= '0;
            phase_reg   <= 1'b0;
        end else if (tick) begin
            div_cnt_reg <= '0;
            phase_reg   <= ~phase_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
        end
    end

    assign sck_rise = tick && !phase_reg;
    assign sck_fall = tick && phase_reg;
    assign SPI_CLK  = phase_reg;

endmodule

// File: rtl/adc_frontend.sv
// ADC front end: programs the pre-amp gain over SPI, then runs convert/read/gap frames
// continuously while en is high. Define ADC_FRONTEND_CH1_EN to also expose the ch1 result
// on sample_ch1; without it the ch1 bits are clocked through and ignored.
module adc_frontend
    import adc_frontend_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] GAIN_INIT = 8'h11,
    parameter int         FRAME_GAP = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                gain_load,
    input  logic [7:0]          gain,
    input  logic                MISO,
    output logic                MOSI,
    output logic                SPI_CLK,
    output logic                CS_AMP,
    output logic                ADC_Conv,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                busy
`ifdef ADC_FRONTEND_CH1_EN
    ,
    output logic [SAMPLE_W-1:0] sample_ch1
`endif
);

`ifdef ADC_FRONTEND_CH1_EN
    localparam int NUM_CH = 2;
`else
    localparam int NUM_CH = 1;
`endif

    state_t              state_reg, state_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [AMP_BITS-1:0] amp_sr_reg, amp_sr_next;
    logic [7:0]          pend_word_reg;
    logic                pend_flag_reg;
    logic                cap_done_reg, cap_next;
    logic                valid_reg;
    logic                sck_rise, sck_fall, sck_phase, run;

    // The IDLE decision cycle already counts as the first divider cycle of the next
    // transaction, so back-to-back frames repeat every (1+34+6)*2*CLK_DIV clk exactly.
    assign run = (state_next != IDLE);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .SPI_CLK  (sck_phase)
    );

    // pending gain word: any request overwrites it (last wins); cleared when IDLE picks it up
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_word_reg <= GAIN_INIT;
            pend_flag_reg <= 1'b1;
        end else if (gain_load) begin
            pend_word_reg <= gain;
            pend_flag_reg <= 1'b1;
        end else if (state_reg == IDLE) begin
            pend_flag_reg <= 1'b0;
        end
    end

    // FSM and shared counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            amp_sr_reg   <= '0;
            cap_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            amp_sr_reg   <= amp_sr_next;
            cap_done_reg <= cap_next;
        end
    end

    // next state: cnt counts falls in AMP_LOAD/GAP and rises in ADC_READ
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        amp_sr_next = amp_sr_reg;
        cap_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (pend_flag_reg) begin
                    amp_sr_next = pend_word_reg;
                    state_next  = AMP_LOAD;
                end else if (en) begin
                    state_next = CONV;
                end
            end
            AMP_LOAD: begin
                if (sck_fall) begin
                    amp_sr_next = {amp_sr_reg[AMP_BITS-2:0], 1'b0};
                    cnt_next    = cnt_reg + 8'd1;
                    if (cnt_reg == 8'(AMP_BITS - 1)) state_next = IDLE;
                end
            end
            CONV: begin
                if (sck_fall) begin
                    cnt_next   = '0;
                    state_next = ADC_READ;
                end
            end
            ADC_READ: begin
                if (sck_rise) begin
                    cnt_next = cnt_reg + 8'd1;
                    cap_next = (cnt_reg == 8'(FRAME_BITS - 1));
                end
                if (sck_fall && (cnt_reg == 8'(FRAME_BITS))) begin
                    cnt_next   = '0;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (sck_fall) begin
                    cnt_next = cnt_reg + 8'd1;
                    if (cnt_reg == 8'(FRAME_GAP - 1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // one capture lane per exposed channel, each shifting in only its own bit window
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int FIRST = (gi == 0) ? CH0_FIRST : CH1_FIRST;
        logic [SAMPLE_W-1:0] sr_reg;
        logic [SAMPLE_W-1:0] out_reg;
        logic                in_window;

        assign in_window = (state_reg == ADC_READ) && sck_rise &&
                           (cnt_reg >= 8'(FIRST - 1)) && (cnt_reg < 8'(FIRST - 1 + SAMPLE_W));

        // shift MSB first during the window; publish once the whole frame has been clocked
        always_ff @(posedge clk) begin
            if (rst) begin
                sr_reg  <= '0;
                out_reg <= '0;
            end else begin
                if (in_window) sr_reg <= {sr_reg[SAMPLE_W-2:0], MISO};
                if (cap_done_reg) out_reg <= sr_reg;
            end
        end
    end

    // sample_valid follows the 34th rising edge by one clk, aligned with the result update
    always_ff @(posedge clk) begin
        if (rst) valid_reg <= 1'b0;
        else     valid_reg <= cap_done_reg;
    end

    assign sample       = g_ch[0].out_reg;
`ifdef ADC_FRONTEND_CH1_EN
    assign sample_ch1   = g_ch[1].out_reg;
`endif
    assign sample_valid = valid_reg;
    assign busy         = (state_reg != IDLE);
    assign CS_AMP       = (state_reg != AMP_LOAD);
    assign ADC_Conv     = (state_reg == CONV);
    assign MOSI         = (state_reg == AMP_LOAD) && amp_sr_reg[AMP_BITS-1];
    assign SPI_CLK      = sck_phase && ((state_reg == AMP_LOAD) || (state_reg == ADC_READ));

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: pre-amp write after reset, table of ADC frames,
// gain reprogramming mid-frame, en dropping mid-frame and reset mid-read.
module tb_adc_frontend;

    localparam int CLK_DIV    = 4;
    localparam int FRAME_CLKS = (1 + 34 + 6) * 2 * CLK_DIV;
    localparam int TMO        = 4 * FRAME_CLKS;
    localparam int NV         = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        gain_load = 1'b0;
    logic [7:0]  gain = 8'h00;
    logic        MISO = 1'b0;
    logic        MOSI, SPI_CLK, CS_AMP, ADC_Conv, sample_valid, busy;
    logic [13:0] sample;
`ifdef ADC_FRONTEND_CH1_EN
    logic [13:0] sample_ch1;
`endif

    always #5 clk = ~clk;

    adc_frontend #(.CLK_DIV(CLK_DIV), .GAIN_INIT(8'h11), .FRAME_GAP(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .gain_load    (gain_load),
        .gain         (gain),
        .MISO         (MISO),
        .MOSI         (MOSI),
        .SPI_CLK      (SPI_CLK),
        .CS_AMP       (CS_AMP),
        .ADC_Conv     (ADC_Conv),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
`ifdef ADC_FRONTEND_CH1_EN
        ,
        .sample_ch1   (sample_ch1)
`endif
    );

    typedef struct {
        logic [13:0] ch0;
        logic [13:0] ch1;
        logic [13:0] exp0;
        logic [13:0] exp1;
    } vec_t;

    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    // monitor / ADC model state
    logic [33:0] adc_word = '0;
    logic [13:0] m_ch0 = '0, m_ch1 = '0;
    logic        spi_p = 1'b0, cs_p = 1'b1, conv_p = 1'b0, val_p = 1'b0;
    logic [7:0]  amp_sr_tb = '0, last_amp = '0;
    int cyc = 0, amp_writes = 0, amp_bits = 0, last_bits = 0, conv_count = 0;
    int valid_pulses = 0, valid_cycles = 0, adc_rises = 0, mosi_viol = 0;
    int last_valid_cyc = 0, last_period = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // bus monitor and ADC model, all sampled half a clk away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (!CS_AMP && cs_p) begin
            amp_sr_tb = '0;
            amp_bits  = 0;
        end
        if (SPI_CLK && !spi_p) begin
            if (!CS_AMP) begin
                amp_sr_tb = {amp_sr_tb[6:0], MOSI};
                amp_bits++;
            end else begin
                adc_rises++;
            end
        end
        if (CS_AMP && !cs_p) begin
            amp_writes++;
            last_amp  = amp_sr_tb;
            last_bits = amp_bits;
        end
        if (ADC_Conv && !conv_p) conv_count++;
        if (CS_AMP && MOSI) mosi_viol++;
        if (sample_valid) begin
            valid_cycles++;
            if (!val_p) begin
                valid_pulses++;
                last_period    = cyc - last_valid_cyc;
                last_valid_cyc = cyc;
            end
        end
        // ADC: frame word loaded at end of convert, bits advanced on each SPI_CLK fall
        if (!ADC_Conv && conv_p) begin
            adc_word = {2'b00, m_ch0, 2'b00, m_ch1, 2'b00};
            MISO     = adc_word[33];
        end else if (!SPI_CLK && spi_p && CS_AMP) begin
            adc_word = {adc_word[32:0], 1'b0};
            MISO     = adc_word[33];
        end
        spi_p  = SPI_CLK;
        cs_p   = CS_AMP;
        conv_p = ADC_Conv;
        val_p  = sample_valid;
    end

    task automatic check_reset(input string pfx);
        check({pfx, "_cs_amp"}, CS_AMP, 1);
        check({pfx, "_spi_clk"}, SPI_CLK, 0);
        check({pfx, "_mosi"}, MOSI, 0);
        check({pfx, "_adc_conv"}, ADC_Conv, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_sample"}, sample, 0);
        check({pfx, "_valid"}, sample_valid, 0);
    endtask

    task automatic wait_valid(input int target, input string name);
        int t = 0;
        while (valid_pulses < target && t < TMO) begin @(negedge clk); t++; end
        check(name, valid_pulses >= target, 1);
    endtask

    task automatic wait_conv(input int target, input string name);
        int t = 0;
        while (conv_count < target && t < TMO) begin @(negedge clk); t++; end
        check(name, conv_count >= target, 1);
    endtask

    task automatic wait_amp(input int target, input string name);
        int t = 0;
        while (amp_writes < target && t < TMO) begin @(negedge clk); t++; end
        check(name, amp_writes >= target, 1);
    endtask

    task automatic wait_rises(input int target, input string name);
        int t = 0;
        while (adc_rises < target && t < TMO) begin @(negedge clk); t++; end
        check(name, adc_rises >= target, 1);
    endtask

    task automatic pulse_gain(input logic [7:0] g);
        gain      = g;
        gain_load = 1'b1;
        @(negedge clk);
        gain_load = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, v0, c0, r0, s;
        vecs[0] = '{14'h1ABC, 14'h0123, 14'h1ABC, 14'h0123};
        vecs[1] = '{14'h2000, 14'h1FFF, 14'h2000, 14'h1FFF};
        vecs[2] = '{14'h1FFF, 14'h2000, 14'h1FFF, 14'h2000};
        vecs[3] = '{14'h3FFF, 14'h0000, 14'h3FFF, 14'h0000};
        vecs[4] = '{14'h0001, 14'h3FFF, 14'h0001, 14'h3FFF};

        // reset state
        repeat (3) @(negedge clk);
        check_reset("reset");

        // power-up amp write of GAIN_INIT with en low
        rst = 1'b0;
        wait_amp(1, "init_amp_timeout");
        check("init_amp_word", last_amp, 8'h11);
        check("init_amp_bits", last_bits, 8);
        repeat (200) @(negedge clk);
        check("init_busy", busy, 0);
        check("init_no_conv", conv_count, 0);

        // frame table with en held high
        en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            m_ch0 = vecs[i].ch0;
            m_ch1 = vecs[i].ch1;
            v0 = valid_pulses;
            wait_valid(v0 + 1, $sformatf("vec%0d_timeout", i));
            check($sformatf("vec%0d_sample", i), sample, vecs[i].exp0);
`ifdef ADC_FRONTEND_CH1_EN
            check($sformatf("vec%0d_ch1", i), sample_ch1, vecs[i].exp1);
`endif
            if (i > 0) check($sformatf("vec%0d_period", i), last_period, FRAME_CLKS);
            if (vecs[i].ch0 == 14'h2000) begin
                s = $signed(sample);
                check("neg_full_scale_sign", s, -8192);
            end
        end

        // gain reprogrammed twice mid-frame: frame completes, single write of last word
        c0 = conv_count;
        wait_conv(c0 + 1, "gain_conv_timeout");
        a0 = amp_writes;
        v0 = valid_pulses;
        pulse_gain(8'h34);
        r0 = adc_rises;
        wait_rises(r0 + 10, "gain_read_timeout");
        pulse_gain(8'h56);
        c0 = conv_count;
        wait_conv(c0 + 1, "gain_next_conv_timeout");
        check("gain_frame_done", valid_pulses, v0 + 1);
        check("gain_one_write", amp_writes, a0 + 1);
        check("gain_word", last_amp, 8'h56);
        check("gain_bits", last_bits, 8);

        // en dropped during convert: frame still delivers, then stays idle
        en = 1'b0;
        v0 = valid_pulses;
        wait_valid(v0 + 1, "enoff_timeout");
        check("enoff_sample", sample, vecs[NV-1].exp0);
        c0 = conv_count;
        repeat (2 * FRAME_CLKS) @(negedge clk);
        check("enoff_no_conv", conv_count, c0);
        check("enoff_busy", busy, 0);

        // reset asserted at read bit 10
        m_ch0 = 14'h1555;
        en = 1'b1;
        c0 = conv_count;
        wait_conv(c0 + 1, "rst_conv_timeout");
        r0 = adc_rises;
        wait_rises(r0 + 10, "rst_read_timeout");
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0;
        v0 = valid_pulses;
        a0 = amp_writes;
        wait_amp(a0 + 1, "rst_amp_timeout");
        check("rst_amp_word", last_amp, 8'h11);
        repeat (100) @(negedge clk);
        check("rst_sample_zero", sample, 0);
        check("rst_no_valid", valid_pulses, v0);

        // global properties observed throughout
        check("mosi_low_when_cs_high", mosi_viol, 0);
        check("valid_one_clk", valid_cycles, valid_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
